// File: rtl/assoc_meta_array.sv
// N-way set-associative tag/metadata store with true-LRU ages, victim reporting
// and a sequential invalidate-all flush engine.
module assoc_meta_array #(
    parameter int SETS  = 64,
    parameter int WAYS  = 2,
    parameter int TAG_W = 6,
    parameter int IDX_W = $clog2(SETS),
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [IDX_W-1:0] req_index,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             req_write,
    input  logic             req_fill,
    input  logic             flush_start,
    output logic             hit,
    output logic [WAY_W-1:0] hit_way,
    output logic [WAY_W-1:0] victim_way,
    output logic             victim_valid,
    output logic             victim_dirty,
    output logic [TAG_W-1:0] victim_tag,
    output logic             busy,
    output logic             flush_done
);

    typedef enum logic [0:0] {IDLE, FLUSH} state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] cnt_reg, cnt_next;
    logic             flush_done_reg, flush_done_next;

    logic [WAYS-1:0]  valid_reg [SETS];
    logic [WAYS-1:0]  dirty_reg [SETS];
    logic [TAG_W-1:0] tag_reg   [SETS][WAYS];
    logic [WAY_W-1:0] age_reg   [SETS][WAYS];

    // Fields of the addressed set
    logic [WAYS-1:0]  set_valid;
    logic [WAYS-1:0]  set_dirty;
    logic [WAYS-1:0]  match;
    logic [TAG_W-1:0] set_tag [WAYS];
    logic [WAY_W-1:0] set_age [WAYS];
    logic [WAY_W-1:0] new_age [WAYS];

    logic             match_any;
    logic [WAY_W-1:0] match_way;
    logic             inv_any;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] lru_way;
    logic [WAY_W-1:0] vict_way;
    logic             accept;
    logic             do_update;
    logic [WAY_W-1:0] acc_way;
    logic [WAY_W-1:0] old_age;
    logic             new_dirty;

    assign set_valid = valid_reg[req_index];
    assign set_dirty = dirty_reg[req_index];

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            assign set_tag[gi] = tag_reg[req_index][gi];
            assign set_age[gi] = age_reg[req_index][gi];
            assign match[gi]   = set_valid[gi] && (set_tag[gi] == req_tag);
            // Accessed way becomes MRU; only younger ways age by one
            assign new_age[gi] = (acc_way == WAY_W'(gi)) ? '0 :
                                 (set_age[gi] < old_age) ? set_age[gi] + 1'b1 :
                                 set_age[gi];
        end
    endgenerate

    always_comb begin
        match_any = 1'b0;
        match_way = '0;
        inv_any   = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        // Descending scans so the lowest index has the final word
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w]) begin
                match_any = 1'b1;
                match_way = WAY_W'(w);
            end
            if (!set_valid[w]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
            if (set_age[w] == WAY_W'(WAYS - 1)) begin
                lru_way = WAY_W'(w);
            end
        end
        vict_way = inv_any ? inv_way : lru_way;
    end

    assign busy       = (state_reg == FLUSH);
    assign flush_done = flush_done_reg;
    assign accept     = req_valid && !busy;
    assign do_update  = accept && (match_any || req_fill);
    assign acc_way    = match_any ? match_way : vict_way;
    assign old_age    = set_age[acc_way];
    assign new_dirty  = match_any ? (set_dirty[acc_way] || req_write) : req_write;

    assign hit          = accept && match_any;
    assign hit_way      = hit ? match_way : '0;
    assign victim_way   = vict_way;
    assign victim_valid = set_valid[vict_way];
    assign victim_dirty = set_dirty[vict_way];
    assign victim_tag   = set_valid[vict_way] ? set_tag[vict_way] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_reg[s] <= '0;
                dirty_reg[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    tag_reg[s][w] <= '0;
                    age_reg[s][w] <= WAY_W'(w);
                end
            end
        end else begin
            for (int s = 0; s < SETS; s++) begin
                if (busy && cnt_reg == IDX_W'(s)) begin
                    valid_reg[s] <= '0;
                    dirty_reg[s] <= '0;
                    for (int w = 0; w < WAYS; w++) begin
                        age_reg[s][w] <= WAY_W'(w);
                    end
                end else if (do_update && req_index == IDX_W'(s)) begin
                    valid_reg[s][acc_way] <= 1'b1;
                    dirty_reg[s][acc_way] <= new_dirty;
                    if (!match_any) begin
                        tag_reg[s][acc_way] <= req_tag;
                    end
                    for (int w = 0; w < WAYS; w++) begin
                        age_reg[s][w] <= new_age[w];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            flush_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            flush_done_reg <= flush_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        flush_done_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (flush_start) begin
                    state_next = FLUSH;
                    cnt_next   = '0;
                end
            end
            FLUSH: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == IDX_W'(SETS - 1)) begin
                    state_next      = IDLE;
                    flush_done_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_assoc_meta_array.sv
// Scoreboard bench: a 2-way/64-set and a 4-way/16-set instance driven by
// directed vectors; expectations are queued per cycle and checked by a monitor.
module tb_assoc_meta_array;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // 2-way instance
    logic       v2, w2, f2, fs2;
    logic [5:0] idx2, tag2;
    logic       h2, vv2, vd2, b2, fd2;
    logic [0:0] hw2, vw2;
    logic [5:0] vt2;

    // 4-way instance
    logic       v4, w4, f4, fs4;
    logic [3:0] idx4;
    logic [5:0] tag4;
    logic       h4, vv4, vd4, b4, fd4;
    logic [1:0] hw4, vw4;
    logic [5:0] vt4;

    assoc_meta_array #(.SETS(64), .WAYS(2), .TAG_W(6)) dut2 (
        .clk(clk), .rst(rst), .req_valid(v2), .req_index(idx2), .req_tag(tag2),
        .req_write(w2), .req_fill(f2), .flush_start(fs2), .hit(h2), .hit_way(hw2),
        .victim_way(vw2), .victim_valid(vv2), .victim_dirty(vd2), .victim_tag(vt2),
        .busy(b2), .flush_done(fd2)
    );

    assoc_meta_array #(.SETS(16), .WAYS(4), .TAG_W(6)) dut4 (
        .clk(clk), .rst(rst), .req_valid(v4), .req_index(idx4), .req_tag(tag4),
        .req_write(w4), .req_fill(f4), .flush_start(fs4), .hit(h4), .hit_way(hw4),
        .victim_way(vw4), .victim_valid(vv4), .victim_dirty(vd4), .victim_tag(vt4),
        .busy(b4), .flush_done(fd4)
    );

    localparam int M_HIT  = 1;
    localparam int M_VW   = 2;
    localparam int M_VV   = 4;
    localparam int M_VD   = 8;
    localparam int M_VT   = 16;
    localparam int M_BUSY = 32;
    localparam int M_FD   = 64;
    localparam int M_ALL  = 127;

    typedef struct {
        int    cyc;
        int    dut;
        string name;
        int    mask;
        int    hit, hw, vw, vv, vd, vt, busy, fd;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   fd_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, string field, int act, int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s.%s actual=0x%0h expected=0x%0h (cycle %0d)", name, field, act, exp_v, cyc);
        end
    endtask

    function automatic void ex(int dut, string name, int mask, int hit, int hw, int vw,
                               int vv, int vd, int vt, int busy, int fd);
        exp_t e;
        e.cyc = cyc; e.dut = dut; e.name = name; e.mask = mask;
        e.hit = hit; e.hw = hw; e.vw = vw; e.vv = vv; e.vd = vd; e.vt = vt;
        e.busy = busy; e.fd = fd;
        q.push_back(e);
    endfunction

    // Monitor: compares every queued expectation belonging to the current cycle
    always @(negedge clk) begin
        exp_t e;
        int a_hit, a_hw, a_vw, a_vv, a_vd, a_vt, a_b, a_fd;
        if (fd2) fd_count++;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.dut == 2) begin
                a_hit = int'(h2); a_hw = int'(hw2); a_vw = int'(vw2); a_vv = int'(vv2);
                a_vd = int'(vd2); a_vt = int'(vt2); a_b = int'(b2); a_fd = int'(fd2);
            end else begin
                a_hit = int'(h4); a_hw = int'(hw4); a_vw = int'(vw4); a_vv = int'(vv4);
                a_vd = int'(vd4); a_vt = int'(vt4); a_b = int'(b4); a_fd = int'(fd4);
            end
            if ((e.mask & M_HIT) != 0) begin
                chk(e.name, "hit", a_hit, e.hit);
                chk(e.name, "hit_way", a_hw, e.hw);
            end
            if ((e.mask & M_VW) != 0)   chk(e.name, "victim_way", a_vw, e.vw);
            if ((e.mask & M_VV) != 0)   chk(e.name, "victim_valid", a_vv, e.vv);
            if ((e.mask & M_VD) != 0)   chk(e.name, "victim_dirty", a_vd, e.vd);
            if ((e.mask & M_VT) != 0)   chk(e.name, "victim_tag", a_vt, e.vt);
            if ((e.mask & M_BUSY) != 0) chk(e.name, "busy", a_b, e.busy);
            if ((e.mask & M_FD) != 0)   chk(e.name, "flush_done", a_fd, e.fd);
            $display("txn %s dut=%0d cycle=%0d hit=%0d way=%0d victim=%0d vvalid=%0d vdirty=%0d vtag=0x%0h busy=%0d fdone=%0d",
                     e.name, e.dut, cyc, a_hit, a_hw, a_vw, a_vv, a_vd, a_vt, a_b, a_fd);
        end
    end

    task automatic drv(int dut, bit v, int idx, int tag, bit w, bit f, bit fs);
        v2 = 0; w2 = 0; f2 = 0; fs2 = 0; idx2 = '0; tag2 = '0;
        v4 = 0; w4 = 0; f4 = 0; fs4 = 0; idx4 = '0; tag4 = '0;
        if (dut == 2) begin
            v2 = v; idx2 = 6'(idx); tag2 = 6'(tag); w2 = w; f2 = f; fs2 = fs;
        end else begin
            v4 = v; idx4 = 4'(idx); tag4 = 6'(tag); w4 = w; f4 = f; fs4 = fs;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one request and queue its full expected response
    task automatic op(int dut, string name, int idx, int tag, bit w, bit f,
                      int hit, int hw, int vw, int vv, int vd, int vt);
        drv(dut, 1'b1, idx, tag, w, f, 1'b0);
        ex(dut, name, M_ALL, hit, hw, vw, vv, vd, vt, 0, 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int g;
        drv(2, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset state across every set
        for (int s = 0; s < 64; s++) op(2, "rst2", s, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int s = 0; s < 16; s++) op(4, "rst4", s, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // 2-way, set 5
        op(2, "s5_fill11", 5, 'h11, 0, 1, 0, 0, 0, 0, 0, 0);
        op(2, "s5_look11", 5, 'h11, 0, 0, 1, 0, 1, 0, 0, 0);
        op(2, "s5_fill22", 5, 'h22, 0, 1, 0, 0, 1, 0, 0, 0);
        op(2, "s5_look22", 5, 'h22, 0, 0, 1, 1, 0, 1, 0, 'h11);
        op(2, "s5_look11b", 5, 'h11, 0, 0, 1, 0, 0, 1, 0, 'h11);
        op(2, "s5_fill33", 5, 'h33, 0, 1, 0, 0, 1, 1, 0, 'h22);
        op(2, "s5_miss22", 5, 'h22, 0, 0, 0, 0, 0, 1, 0, 'h11);
        op(2, "s5_look33", 5, 'h33, 0, 0, 1, 1, 0, 1, 0, 'h11);

        // 4-way, set 9: LRU ordering
        op(4, "s9_fillA", 9, 'h0A, 0, 1, 0, 0, 0, 0, 0, 0);
        op(4, "s9_fillB", 9, 'h0B, 0, 1, 0, 0, 1, 0, 0, 0);
        op(4, "s9_fillC", 9, 'h0C, 0, 1, 0, 0, 2, 0, 0, 0);
        op(4, "s9_fillD", 9, 'h0D, 0, 1, 0, 0, 3, 0, 0, 0);
        op(4, "s9_hitA", 9, 'h0A, 0, 0, 1, 0, 0, 1, 0, 'h0A);
        op(4, "s9_hitC", 9, 'h0C, 0, 0, 1, 2, 1, 1, 0, 'h0B);
        op(4, "s9_fillE", 9, 'h0E, 0, 1, 0, 0, 1, 1, 0, 'h0B);
        op(4, "s9_lookE", 9, 'h0E, 0, 0, 1, 1, 3, 1, 0, 'h0D);
        op(4, "s9_missB", 9, 'h0B, 0, 0, 0, 0, 3, 1, 0, 'h0D);

        // Set 3: dirty tracking, miss without fill, fill ignored on hit
        op(2, "s3_fill2A", 3, 'h2A, 0, 1, 0, 0, 0, 0, 0, 0);
        op(2, "s3_wrhit", 3, 'h2A, 1, 0, 1, 0, 1, 0, 0, 0);
        op(2, "s3_fill15", 3, 'h15, 0, 1, 0, 0, 1, 0, 0, 0);
        op(2, "s3_miss3F", 3, 'h3F, 0, 0, 0, 0, 0, 1, 1, 'h2A);
        op(2, "s3_miss3Fb", 3, 'h3F, 0, 0, 0, 0, 0, 1, 1, 'h2A);
        op(2, "s3_look15", 3, 'h15, 0, 0, 1, 1, 0, 1, 1, 'h2A);
        op(2, "s3_hitfill", 3, 'h2A, 0, 1, 1, 0, 0, 1, 1, 'h2A);
        op(2, "s3_look15b", 3, 'h15, 0, 0, 1, 1, 1, 1, 0, 'h15);

        // Flush sweep
        op(2, "fl_fill0", 0, 'h01, 0, 1, 0, 0, 0, 0, 0, 0);
        op(2, "fl_fill7", 7, 'h02, 0, 1, 0, 0, 0, 0, 0, 0);
        op(2, "fl_fill63", 63, 'h03, 1, 1, 0, 0, 0, 0, 0, 0);
        op(2, "fl_look0", 0, 'h01, 0, 0, 1, 0, 1, 0, 0, 0);
        drv(2, 0, 0, 0, 0, 0, 1);
        ex(2, "fl_start", M_BUSY | M_FD, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int k = 1; k <= 64; k++) begin
            drv(2, 1, 0, 'h01, 0, 1, k == 10);
            ex(2, "fl_busy", M_HIT | M_BUSY | M_FD, 0, 0, 0, 0, 0, 0, 1, 0);
            tick();
        end
        drv(2, 0, 0, 0, 0, 0, 0);
        ex(2, "fl_done", M_BUSY | M_FD, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        op(2, "fl_after0", 0, 'h01, 0, 0, 0, 0, 0, 0, 0, 0);
        op(2, "fl_after7", 7, 'h02, 0, 0, 0, 0, 0, 0, 0, 0);
        op(2, "fl_after63", 63, 'h03, 0, 0, 0, 0, 0, 0, 0, 0);
        op(2, "fl_after5", 5, 'h33, 0, 0, 0, 0, 0, 0, 0, 0);
        op(2, "fl_after3", 3, 'h2A, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset during flush
        op(2, "rf_fill12", 12, 'h05, 0, 1, 0, 0, 0, 0, 0, 0);
        op(4, "rf_fill4w", 2, 'h07, 0, 1, 0, 0, 0, 0, 0, 0);
        drv(2, 0, 0, 0, 0, 0, 1);
        ex(2, "rf_start", M_BUSY, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drv(2, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k < 20; k++) begin
            ex(2, "rf_busy", M_BUSY | M_FD, 0, 0, 0, 0, 0, 0, 1, 0);
            tick();
        end
        rst = 1'b0;
        #1;
        chk("rf_async", "busy", int'(b2), 0);
        #1;
        rst = 1'b1;
        tick();
        for (g = 0; g < 4; g++) begin
            op(2, "rf_after12", 12, 'h05, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        op(4, "rf_after4w", 2, 'h07, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(2, 0, 0, 0, 0, 0, 0);
        repeat (70) begin
            ex(2, "rf_idle", M_BUSY | M_FD, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end

        g = 0;
        while (q.size() > 0 && g < 10) begin
            tick();
            g++;
        end
        chk("queue", "drained", q.size(), 0);
        chk("flush", "done_pulses", fd_count, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/assoc_meta_array.md
Name: assoc_meta_array

Overview:
- Parametrised N-way set-associative tag/metadata store for the cache processor.
- Next generation of the 2-way tag array:
  - binary set index instead of one-hot block enable
  - configurable sets, ways and tag width
  - per-line dirty bit
  - true-LRU age counters
  - victim reporting for writeback
  - sequential flush engine that invalidates every set
- Sits beside the data array. The cache controller uses it for hit/way lookup and for victim selection on fill.

Parameters:
SETS, 64, number of sets; power of 2, ≥2
WAYS, 2, associativity; power of 2, 2..8
TAG_W, 6, tag width in bits
IDX_W, log2(SETS), derived; set-index width
WAY_W, log2(WAYS), derived; way-number and LRU-age width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low
req_valid  in  1  lookup/update request this cycle
req_index  in  IDX_W  set index
req_tag  in  TAG_W  tag to compare or install
req_write  in  1  on hit: set dirty; on fill: installed line dirty value
req_fill  in  1  install req_tag into the victim way if it misses
flush_start  in  1  start invalidate-all sweep
hit  out  1  req_tag valid in set req_index
hit_way  out  WAY_W  matching way; 0 when hit=0
victim_way  out  WAY_W  way a fill would replace
victim_valid  out  1  victim way currently holds a valid line
victim_dirty  out  1  victim line dirty (writeback needed)
victim_tag  out  TAG_W  victim line tag; 0 if victim invalid
busy  out  1  flush in progress
flush_done  out  1  one-cycle pulse at end of flush

Behaviour:
- Per line storage: valid, dirty, tag[TAG_W], age[WAY_W]. Within a set, ages are always a permutation of 0..WAYS-1. Age 0 = MRU, WAYS-1 = LRU.
- Reset (rst=0, async):
  - all valid and dirty = 0; age of way w = w
  - FSM to IDLE; busy=0, flush_done=0
- Lookup is combinational from stored state and req_index/req_tag (0-cycle):
  - hit = req_valid & ~busy & any way (valid & tag==req_tag)
  - Several matching ways cannot occur; if they did, lowest index wins.
- Victim selection (combinational, every cycle, independent of req_valid):
  - lowest-indexed invalid way, else the way with age WAYS-1
  - victim_valid/dirty/tag are that way's fields
- Updates at the rising edge when req_valid & ~busy:
  - Hit: accessed way's age←0; every way whose age was below the old age increments; others unchanged. If req_write, dirty←1. req_fill is ignored on hit (no duplicate install).
  - Miss & req_fill: victim gets valid←1, tag←req_tag, dirty←req_write, and the same age update as a hit.
  - Miss & ~req_fill: no state change.
- Flush FSM:
  - IDLE→FLUSH on flush_start & ~busy. Set counter starts at 0 and busy=1 from the next cycle.
  - FLUSH, each cycle: set[counter] gets valid←0, dirty←0, age of way w←w; counter++.
  - After set SETS-1 is cleared: →IDLE, busy←0, flush_done=1 for exactly one cycle.
  - Duration: busy high for exactly SETS cycles.
- While busy: requests are ignored (hit=0, no updates) and flush_start is ignored.
- flush_start and req_valid in the same IDLE cycle: the request is processed that edge, then the flush begins.
- Reset mid-flush: immediate return to IDLE with all state cleared; no flush_done pulse.

Test Plan:
- After reset, lookup every set with tag 0 → hit=0, victim_way=0, victim_valid=0, busy=0.
- WAYS=2, set 5:
  - fill 0x11 → victim_way=0; next cycle 0x11 hits way0 and victim_way=1.
  - fill 0x22 → way1.
  - lookup 0x11 → victim_way=1; fill 0x33 replaces 0x22; 0x22 now misses.
- WAYS=4, set 9:
  - fill tags A,B,C,D into ways 0..3, then hit A, then hit C → victim_way=1 (B).
  - fill E → lands in way1; victim_valid=1, victim_tag=B seen before the edge.
- Set 3:
  - fill 0x2A with req_write=0, then write-hit → victim_dirty=1 when that line is victim.
  - miss without req_fill → no state change.
- Fill sets 0,7,63, then pulse flush_start:
  - busy=1 for 64 cycles; requests during busy → hit=0
  - flush_done pulses once; afterwards all lookups miss and victim_way=0
- Assert rst=0 at flush cycle 20 → busy drops asynchronously, no flush_done pulse, all sets invalid after release.
